// File: rtl/mem_pkg.sv
// Shared encodings for the flash transaction sequencer: port opcodes,
// flash command bytes, FSM state codes and the default burst length.
package mem_pkg;

    typedef enum logic [1:0] {
        CMD_READ    = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_ERASE   = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_op_t;

    localparam logic [7:0] FL_WREN = 8'h06;
    localparam logic [7:0] FL_READ = 8'h03;
    localparam logic [7:0] FL_PP   = 8'h02;
    localparam logic [7:0] FL_SE   = 8'h20;
    localparam logic [7:0] FL_RDSR = 8'h05;

    localparam int TXN_LEN_DEF = 32;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WREN     = 4'd1;
    localparam logic [3:0] ST_GAP      = 4'd2;
    localparam logic [3:0] ST_OPC      = 4'd3;
    localparam logic [3:0] ST_ADDR     = 4'd4;
    localparam logic [3:0] ST_RDATA    = 4'd5;
    localparam logic [3:0] ST_RHOLD    = 4'd6;
    localparam logic [3:0] ST_WDATA    = 4'd7;
    localparam logic [3:0] ST_POLL_OPC = 4'd8;
    localparam logic [3:0] ST_POLL     = 4'd9;
    localparam logic [3:0] ST_DONE     = 4'd10;

    // States that own exactly one SPI byte shift at a time.
    function automatic logic is_byte_slot(input logic [3:0] s);
        return (s == ST_WREN) || (s == ST_OPC) || (s == ST_ADDR) ||
               (s == ST_RDATA) || (s == ST_WDATA) ||
               (s == ST_POLL_OPC) || (s == ST_POLL);
    endfunction

endpackage

// File: rtl/mem_txn_sequencer.sv
// Expands one port command into the flash byte sequence (WREN, opcode, address,
// data, status polling). Define MEM_TXN_TIMEOUT_EN to bound status polling by POLL_MAX.
module mem_txn_sequencer
    import mem_pkg::*;
#(
    parameter int TXN_LEN  = TXN_LEN_DEF,
    parameter int CS_GAP   = 2,
    parameter int POLL_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_cmd_valid,
    output logic        out_cmd_ready,
    input  logic [1:0]  in_cmd_opcode,
    input  logic [23:0] in_cmd_addr,
    output logic        out_rd_valid,
    output logic [7:0]  out_rd_data,
    input  logic        in_rd_ack,
    input  logic        in_wr_valid,
    input  logic [7:0]  in_wr_data,
    output logic        out_wr_ready,
    output logic        out_done,
    output logic        out_err,
    output logic        out_spi_cs_n,
    output logic        out_spi_start,
    output logic [7:0]  out_spi_tx,
    input  logic        in_spi_done,
    input  logic [7:0]  in_spi_rx
);

    localparam int CNT_W = $clog2(TXN_LEN + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    if (TXN_LEN < 1 || TXN_LEN > 256 || CS_GAP < 1 || POLL_MAX < 1) begin : g_bad_param
        $error("mem_txn_sequencer: parameter out of range");
    end

    logic [3:0]       state;
    logic [3:0]       gap_next;
    logic [1:0]       op;
    logic [23:0]      addr;
    logic [1:0]       addr_idx;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             issued;
    logic [7:0]       wdata;
    logic             cs_n;
    logic             err;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             start;
    logic             byte_done;
    logic             wr_accept;
    logic [7:0]       tx;

`ifdef MEM_TXN_TIMEOUT_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    logic [PW-1:0] poll_cnt;
`endif

    // issued marks the single byte in flight; done pulses outside it are ignored.
    always_comb begin
        wr_accept = (state == ST_WDATA) && !issued && in_wr_valid;
        start     = is_byte_slot(state) && !issued && ((state != ST_WDATA) || in_wr_valid);
        byte_done = issued && in_spi_done;
    end

    always_comb begin
        tx = 8'h00;
        case (state)
            ST_WREN:     tx = FL_WREN;
            ST_OPC:      tx = (op == CMD_READ) ? FL_READ : ((op == CMD_WRITE) ? FL_PP : FL_SE);
            ST_ADDR: begin
                case (addr_idx)
                    2'd0:    tx = addr[23:16];
                    2'd1:    tx = addr[15:8];
                    default: tx = addr[7:0];
                endcase
            end
            ST_WDATA:    tx = issued ? wdata : in_wr_data;
            ST_POLL_OPC: tx = FL_RDSR;
            default:     tx = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gap_next <= ST_IDLE;
            op       <= 2'b00;
            addr     <= 24'h0;
            addr_idx <= 2'd0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            issued   <= 1'b0;
            wdata    <= 8'h00;
            cs_n     <= 1'b1;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
`ifdef MEM_TXN_TIMEOUT_EN
            poll_cnt <= '0;
`endif
        end else begin
            if (start)
                issued <= 1'b1;
            else if (byte_done)
                issued <= 1'b0;
            if (wr_accept)
                wdata <= in_wr_data;

            case (state)
                ST_IDLE: begin
                    if (in_cmd_valid) begin
                        op       <= in_cmd_opcode;
                        addr     <= in_cmd_addr;
                        addr_idx <= 2'd0;
                        byte_cnt <= CNT_W'(TXN_LEN);
                        case (in_cmd_opcode)
                            CMD_READ: begin
                                cs_n  <= 1'b0;
                                state <= ST_OPC;
                            end
                            CMD_WRITE, CMD_ERASE: begin
                                cs_n  <= 1'b0;
                                state <= ST_WREN;
                            end
                            default: begin
                                err   <= 1'b1;
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_WREN: begin
                    if (byte_done) begin
                        cs_n     <= 1'b1;
                        gap_cnt  <= GAP_W'(CS_GAP - 1);
                        gap_next <= ST_OPC;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        cs_n  <= 1'b0;
                        state <= gap_next;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_OPC: begin
                    if (byte_done)
                        state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        if (addr_idx == 2'd2) begin
                            case (op)
                                CMD_READ:  state <= ST_RDATA;
                                CMD_WRITE: state <= ST_WDATA;
                                default: begin
                                    cs_n     <= 1'b1;
                                    gap_cnt  <= GAP_W'(CS_GAP - 1);
                                    gap_next <= ST_POLL_OPC;
                                    state    <= ST_GAP;
                                end
                            endcase
                        end else begin
                            addr_idx <= addr_idx + 2'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (byte_done) begin
                        rd_data  <= in_spi_rx;
                        rd_valid <= 1'b1;
                        state    <= ST_RHOLD;
                    end
                end
                ST_RHOLD: begin
                    if (in_rd_ack) begin
                        rd_valid <= 1'b0;
                        if (byte_cnt == CNT_W'(1)) begin
                            cs_n  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            byte_cnt <= byte_cnt - CNT_W'(1);
                            state    <= ST_RDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        if (byte_cnt == CNT_W'(1)) begin
                            cs_n     <= 1'b1;
                            gap_cnt  <= GAP_W'(CS_GAP - 1);
                            gap_next <= ST_POLL_OPC;
                            state    <= ST_GAP;
                        end else begin
                            byte_cnt <= byte_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_POLL_OPC: begin
                    if (byte_done) begin
`ifdef MEM_TXN_TIMEOUT_EN
                        poll_cnt <= PW'(POLL_MAX);
`endif
                        state <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (byte_done) begin
                        if (!in_spi_rx[0]) begin
                            cs_n  <= 1'b1;
                            state <= ST_DONE;
                        end
`ifdef MEM_TXN_TIMEOUT_EN
                        else if (poll_cnt == PW'(1)) begin
                            cs_n  <= 1'b1;
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            poll_cnt <= poll_cnt - PW'(1);
                        end
`endif
                    end
                end
                ST_DONE: begin
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    cs_n  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_cmd_ready = (state == ST_IDLE);
    assign out_done      = (state == ST_DONE);
    assign out_err       = err;
    assign out_rd_valid  = rd_valid;
    assign out_rd_data   = rd_data;
    assign out_wr_ready  = wr_accept;
    assign out_spi_cs_n  = cs_n;
    assign out_spi_start = start;
    assign out_spi_tx    = tx;

endmodule

// File: tb/tb_mem_txn_sequencer.sv
// Directed bench for mem_txn_sequencer with a behavioural SPI byte shifter,
// a delayed read consumer and a gapped write source.
module tb_mem_txn_sequencer;
    import mem_pkg::*;

    localparam int TXN_LEN  = 4;
    localparam int CS_GAP   = 2;
    localparam int POLL_MAX = 8;

    logic        clk, rst_n;
    logic        in_cmd_valid, out_cmd_ready;
    logic [1:0]  in_cmd_opcode;
    logic [23:0] in_cmd_addr;
    logic        out_rd_valid, in_rd_ack;
    logic [7:0]  out_rd_data;
    logic        in_wr_valid, out_wr_ready;
    logic [7:0]  in_wr_data;
    logic        out_done, out_err;
    logic        out_spi_cs_n, out_spi_start, in_spi_done;
    logic [7:0]  out_spi_tx, in_spi_rx;

    mem_txn_sequencer #(.TXN_LEN(TXN_LEN), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
        .in_cmd_opcode(in_cmd_opcode), .in_cmd_addr(in_cmd_addr),
        .out_rd_valid(out_rd_valid), .out_rd_data(out_rd_data), .in_rd_ack(in_rd_ack),
        .in_wr_valid(in_wr_valid), .in_wr_data(in_wr_data), .out_wr_ready(out_wr_ready),
        .out_done(out_done), .out_err(out_err),
        .out_spi_cs_n(out_spi_cs_n), .out_spi_start(out_spi_start), .out_spi_tx(out_spi_tx),
        .in_spi_done(in_spi_done), .in_spi_rx(in_spi_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [23:0]  addr;
        int           n_tx;
        logic [159:0] tx;
        int           n_rx;
        logic [159:0] rx;
        int           n_wr;
        logic [31:0]  wr;
        int           n_rd;
        logic [31:0]  rd;
        int           n_falls;
        logic         err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] rx_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rx_default = 8'h00;
    int  done_cnt, err_at_done, wr_cnt, falls, min_gap, cs_run;
    int  overlap_errs, csn_errs, wr_gap;
    bit  busy, ack_pend, prev_cs;
    int  lat, ack_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [159:0] v, input int n, input int i);
        return v[(n - 1 - i) * 8 +: 8];
    endfunction

    // SPI shifter model, read consumer and bus monitors, all sampled mid-low-phase.
    initial begin
        in_spi_done = 1'b0; in_spi_rx = 8'h00; in_rd_ack = 1'b0;
        busy = 0; ack_pend = 0; prev_cs = 1; lat = 0; ack_cnt = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                busy = 0; in_spi_done = 1'b0; ack_pend = 0; in_rd_ack = 1'b0; prev_cs = 1;
            end else begin
                bit was_busy;
                was_busy = busy;
                if (in_spi_done) in_spi_done = 1'b0;
                if (busy) begin
                    lat--;
                    if (lat == 0) begin
                        busy = 0;
                        in_spi_done = 1'b1;
                        in_spi_rx = (rx_q.size() > 0) ? rx_q.pop_front() : rx_default;
                    end
                end
                if (out_spi_start) begin
                    if (was_busy) overlap_errs++;
                    if (out_spi_cs_n) csn_errs++;
                    tx_log.push_back(out_spi_tx);
                    busy = 1; lat = 3;
                end
                if (!out_spi_cs_n && prev_cs) begin
                    falls++;
                    if (falls > 1 && cs_run < min_gap) min_gap = cs_run;
                end
                cs_run  = out_spi_cs_n ? cs_run + 1 : 0;
                prev_cs = out_spi_cs_n;
                if (out_wr_ready) wr_cnt++;
                if (out_done) begin done_cnt++; err_at_done = out_err; end
                if (in_rd_ack) in_rd_ack = 1'b0;
                else if (out_rd_valid) begin
                    if (!ack_pend) begin ack_pend = 1; ack_cnt = 3; end
                    else begin
                        ack_cnt--;
                        if (ack_cnt == 0) begin
                            rd_log.push_back(out_rd_data);
                            in_rd_ack = 1'b1;
                            ack_pend = 0;
                        end
                    end
                end
            end
        end
    end

    // Write source: idles two cycles between bytes, holds valid until accepted.
    initial begin
        in_wr_valid = 1'b0; in_wr_data = 8'h00; wr_gap = 1;
        forever begin
            @(negedge clk);
            if (!rst_n || wr_q.size() == 0) in_wr_valid = 1'b0;
            else if (wr_gap > 0) begin in_wr_valid = 1'b0; wr_gap--; end
            else begin
                in_wr_valid = 1'b1;
                in_wr_data  = wr_q[0];
                #1;
                if (out_wr_ready) begin void'(wr_q.pop_front()); wr_gap = 2; end
            end
        end
    end

    task automatic clear_logs();
        tx_log.delete(); rd_log.delete(); rx_q.delete(); wr_q.delete();
        done_cnt = 0; err_at_done = 0; wr_cnt = 0; falls = 0; min_gap = 999; cs_run = 0;
        overlap_errs = 0; csn_errs = 0; wr_gap = 1;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [23:0] addr);
        @(negedge clk);
        in_cmd_valid = 1'b1; in_cmd_opcode = op; in_cmd_addr = addr;
        @(posedge clk); #1;
        in_cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cycles, n;
        clear_logs();
        for (int i = 0; i < v.n_rx; i++) rx_q.push_back(byte_at(v.rx, v.n_rx, i));
        for (int i = 0; i < v.n_wr; i++) wr_q.push_back(byte_at({128'h0, v.wr}, v.n_wr, i));
        check($sformatf("%s idle_ready", tag), out_cmd_ready, 1);
        issue_cmd(v.op, v.addr);
        cycles = 0;
        while (done_cnt == 0 && cycles < 3000) begin @(negedge clk); #3; cycles++; end
        if (v.op == CMD_ILLEGAL) check($sformatf("%s done_within_3", tag), cycles <= 3, 1);
        repeat (3) begin @(negedge clk); #3; end
        check($sformatf("%s done_count", tag), done_cnt, 1);
        check($sformatf("%s err", tag), err_at_done, v.err);
        check($sformatf("%s tx_count", tag), tx_log.size(), v.n_tx);
        n = (tx_log.size() < v.n_tx) ? tx_log.size() : v.n_tx;
        for (int i = 0; i < n; i++)
            check($sformatf("%s tx[%0d]", tag, i), tx_log[i], byte_at(v.tx, v.n_tx, i));
        check($sformatf("%s rd_count", tag), rd_log.size(), v.n_rd);
        n = (rd_log.size() < v.n_rd) ? rd_log.size() : v.n_rd;
        for (int i = 0; i < n; i++)
            check($sformatf("%s rd[%0d]", tag, i), rd_log[i], byte_at({128'h0, v.rd}, v.n_rd, i));
        check($sformatf("%s wr_ready_pulses", tag), wr_cnt, v.n_wr);
        check($sformatf("%s cs_falls", tag), falls, v.n_falls);
        if (v.n_falls > 1) check($sformatf("%s cs_gap_ok", tag), min_gap >= CS_GAP, 1);
        check($sformatf("%s overlap", tag), overlap_errs, 0);
        check($sformatf("%s start_with_cs_high", tag), csn_errs, 0);
        check($sformatf("%s ready_after", tag), out_cmd_ready, 1);
        check($sformatf("%s cs_n_after", tag), out_spi_cs_n, 1);
        check($sformatf("%s err_cleared", tag), out_err, 0);
    endtask

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{op: CMD_READ, addr: 24'h123456,
                    n_tx: 8, tx: {8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00},
                    n_rx: 8, rx: {8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD},
                    n_wr: 0, wr: 32'h0,
                    n_rd: 4, rd: {8'hAA, 8'hBB, 8'hCC, 8'hDD},
                    n_falls: 1, err: 1'b0};
        vecs[1] = '{op: CMD_WRITE, addr: 24'h000100,
                    n_tx: 13, tx: {8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03,
                                   8'h04, 8'h05, 8'h00, 8'h00, 8'h00},
                    n_rx: 13, rx: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                   8'hFF, 8'hFF, 8'h03, 8'h03, 8'h00},
                    n_wr: 4, wr: {8'h01, 8'h02, 8'h03, 8'h04},
                    n_rd: 0, rd: 32'h0,
                    n_falls: 3, err: 1'b0};
        vecs[2] = '{op: CMD_ERASE, addr: 24'hFFF000,
                    n_tx: 8, tx: {8'h06, 8'h20, 8'hFF, 8'hF0, 8'h00, 8'h05, 8'h00, 8'h00},
                    n_rx: 8, rx: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00},
                    n_wr: 0, wr: 32'h0,
                    n_rd: 0, rd: 32'h0,
                    n_falls: 3, err: 1'b0};
        vecs[3] = '{op: CMD_ILLEGAL, addr: 24'h000000,
                    n_tx: 0, tx: 160'h0, n_rx: 0, rx: 160'h0,
                    n_wr: 0, wr: 32'h0, n_rd: 0, rd: 32'h0,
                    n_falls: 0, err: 1'b1};

        rst_n = 1'b0; in_cmd_valid = 1'b0; in_cmd_opcode = 2'b00; in_cmd_addr = 24'h0;
        clear_logs();
        repeat (2) @(negedge clk);
        #3;
        check("reset cmd_ready", out_cmd_ready, 1);
        check("reset cs_n", out_spi_cs_n, 1);
        check("reset spi_start", out_spi_start, 0);
        check("reset spi_tx", out_spi_tx, 0);
        check("reset done", out_done, 0);
        check("reset err", out_err, 0);
        check("reset rd_valid", out_rd_valid, 0);
        check("reset rd_data", out_rd_data, 0);
        check("reset wr_ready", out_wr_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset while the second address byte is on the wire.
        begin
            int cycles;
            clear_logs();
            issue_cmd(CMD_READ, 24'h123456);
            cycles = 0;
            while (tx_log.size() < 3 && cycles < 200) begin @(negedge clk); #3; cycles++; end
            check("midrst reached_addr1", tx_log.size(), 3);
            rst_n = 1'b0;
            #1;
            check("midrst cs_n", out_spi_cs_n, 1);
            check("midrst cmd_ready", out_cmd_ready, 1);
            check("midrst rd_valid", out_rd_valid, 0);
            check("midrst spi_start", out_spi_start, 0);
            check("midrst done", out_done, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            #3;
            check("midrst no_done_pulse", done_cnt, 0);
            run_vec(vecs[0], "reread");
        end

`ifdef MEM_TXN_TIMEOUT_EN
        begin
            vec_t t;
            t = '{op: CMD_ERASE, addr: 24'h000200,
                  n_tx: 14, tx: {8'h06, 8'h20, 8'h00, 8'h02, 8'h00, 8'h05,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  n_rx: 0, rx: 160'h0, n_wr: 0, wr: 32'h0, n_rd: 0, rd: 32'h0,
                  n_falls: 3, err: 1'b1};
            rx_default = 8'h01;
            run_vec(t, "timeout");
            rx_default = 8'h00;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
